// File: rtl/acondicionador_pulsadores_ad.sv
// Push-button conditioner: two-flop synchronizer and debouncer per button, then a shared FSM
// issuing one-cycle enUP/enDOWN pulses. Define AUTOREPEAT_EN to enable auto-repeat while held.
module acondicionador_pulsadores_ad #(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES = 20,
  parameter int unsigned REP_CYCLES  = 8,
  parameter int unsigned CNT_W       = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic enUP,
  output logic enDOWN
);

  if (DEB_CYCLES < 1 || 64'(DEB_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_deb
    $error("DEB_CYCLES must be >= 1 and < 2**CNT_W");
  end
  if (HOLD_CYCLES < 2 || 64'(HOLD_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_hold
    $error("HOLD_CYCLES must be >= 2 and < 2**CNT_W");
  end
  if (REP_CYCLES < 2 || 64'(REP_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_rep
    $error("REP_CYCLES must be >= 2 and < 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
`ifdef AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYCLES - 1);
`endif

  typedef enum logic [1:0] {IDLE, ARMED, REPEAT, LOCK} state_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  // Bit 0 is the up button, bit 1 the down button throughout.
  logic [1:0] raw;
  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] stable;

  assign raw = {btn_down, btn_up};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: synchronizer flops are reset as well, so a button held across reset is seen as a fresh press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_deb
    logic [CNT_W-1:0] deb_tmr;
    logic             st;

    // Accept a new level only after it has differed from the current one for DEB_CYCLES samples.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        deb_tmr <= '0;
        st      <= 1'b0;
      end else if (s2[i] == st) begin
        deb_tmr <= '0;
      end else if (deb_tmr == DEB_LAST) begin
        st      <= s2[i];
        deb_tmr <= '0;
      end else begin
        deb_tmr <= deb_tmr + CNT_W'(1);
      end
    end

    assign stable[i] = st;
  end

  logic up_st;
  logic dn_st;
  assign up_st = stable[0];
  assign dn_st = stable[1];

  state_t           state;
  state_t           state_nx;
  dir_t             dir;
  dir_t             dir_nx;
  logic [CNT_W-1:0] tmr;
  logic [CNT_W-1:0] tmr_nx;
  logic             up_nx;
  logic             dn_nx;
  logic             sel_held;
  logic             opp_held;

  assign sel_held = (dir == DIR_UP) ? up_st : dn_st;
  assign opp_held = (dir == DIR_UP) ? dn_st : up_st;

  // NOTE: every always_comb output is defaulted first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    dir_nx   = dir;
    tmr_nx   = tmr;
    up_nx    = 1'b0;
    dn_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        tmr_nx = '0;
        if (up_st && !dn_st) begin
          up_nx    = 1'b1;
          dir_nx   = DIR_UP;
          state_nx = ARMED;
        end else if (dn_st && !up_st) begin
          dn_nx    = 1'b1;
          dir_nx   = DIR_DOWN;
          state_nx = ARMED;
        end else if (up_st && dn_st) begin
          state_nx = LOCK;
        end
      end
      ARMED: begin
        if (!sel_held) begin
          tmr_nx   = '0;
          state_nx = IDLE;
        end else if (opp_held) begin
          tmr_nx   = '0;
          state_nx = LOCK;
`ifdef AUTOREPEAT_EN
        end else if (tmr == HOLD_LAST) begin
          up_nx    = (dir == DIR_UP);
          dn_nx    = (dir == DIR_DOWN);
          tmr_nx   = '0;
          state_nx = REPEAT;
        end else begin
          tmr_nx = tmr + CNT_W'(1);
        end
`else
        end else begin
          tmr_nx = '0;
        end
`endif
      end
      REPEAT: begin
`ifdef AUTOREPEAT_EN
        if (!sel_held) begin
          tmr_nx   = '0;
          state_nx = IDLE;
        end else if (opp_held) begin
          tmr_nx   = '0;
          state_nx = LOCK;
        end else if (tmr == REP_LAST) begin
          up_nx  = (dir == DIR_UP);
          dn_nx  = (dir == DIR_DOWN);
          tmr_nx = '0;
        end else begin
          tmr_nx = tmr + CNT_W'(1);
        end
`else
        // Unreachable without auto-repeat; fall back to IDLE if ever entered.
        tmr_nx   = '0;
        state_nx = IDLE;
`endif
      end
      LOCK: begin
        tmr_nx = '0;
        if (!up_st && !dn_st) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      dir    <= DIR_UP;
      tmr    <= '0;
      enUP   <= 1'b0;
      enDOWN <= 1'b0;
    end else begin
      state  <= state_nx;
      dir    <= dir_nx;
      tmr    <= tmr_nx;
      enUP   <= up_nx;
      enDOWN <= dn_nx;
    end
  end

`ifndef SYNTHESIS
  a_exclusive : assert property (@(posedge clk) disable iff (!reset) !(enUP && enDOWN));
  a_up_single : assert property (@(posedge clk) disable iff (!reset) enUP |=> !enUP);
  a_dn_single : assert property (@(posedge clk) disable iff (!reset) enDOWN |=> !enDOWN);
`endif

endmodule

// File: tb/tb_acondicionador_pulsadores_ad.sv
// Self-checking bench for acondicionador_pulsadores_ad: directed test-plan scenarios plus random
// button activity, compared cycle by cycle against a behavioural model. Honours AUTOREPEAT_EN.
module tb_acondicionador_pulsadores_ad;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;
`ifdef AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_HELD = 1;
  localparam int M_LOCK = 2;

  logic clk = 1'b0;
  logic reset;
  logic btn_up;
  logic btn_down;
  logic enUP;
  logic enDOWN;

  always #5 clk = ~clk;

  acondicionador_pulsadores_ad #(
    .DEB_CYCLES (DEB),
    .HOLD_CYCLES(HOLD),
    .REP_CYCLES (REP),
    .CNT_W      (24)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .enUP    (enUP),
    .enDOWN  (enDOWN)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int idx   = 0;
  int up_idx[$];
  int dn_idx[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: sampling pipeline, run-length debounce, and a press-age based pulse schedule.
  bit [1:0] m_s1, m_s2, m_st;
  int       m_run[2];
  int       m_mode;
  bit       m_dir;
  int       m_age;
  bit       exp_up, exp_dn;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_st = '0;
    m_run[0] = 0; m_run[1] = 0;
    m_mode = M_IDLE; m_dir = 1'b0; m_age = 0;
    exp_up = 1'b0; exp_dn = 1'b0;
  endtask

  task automatic model_edge(input bit raw_up, input bit raw_dn);
    bit u, d, sel, opp;
    u = m_st[0];
    d = m_st[1];
    exp_up = 1'b0;
    exp_dn = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (u && !d) begin
          exp_up = 1'b1; m_dir = 1'b0; m_age = 0; m_mode = M_HELD;
        end else if (d && !u) begin
          exp_dn = 1'b1; m_dir = 1'b1; m_age = 0; m_mode = M_HELD;
        end else if (u && d) begin
          m_mode = M_LOCK;
        end
      end
      M_HELD: begin
        sel = m_dir ? d : u;
        opp = m_dir ? u : d;
        if (!sel) m_mode = M_IDLE;
        else if (opp) m_mode = M_LOCK;
        else begin
          m_age++;
          if (AR && (m_age == HOLD || (m_age > HOLD && (m_age - HOLD) % REP == 0))) begin
            exp_up = !m_dir;
            exp_dn = m_dir;
          end
        end
      end
      default: if (!u && !d) m_mode = M_IDLE;
    endcase
    for (int i = 0; i < 2; i++) begin
      if (m_s2[i] != m_st[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_st[i]  = m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = {raw_dn, raw_up};
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_edge(btn_up, btn_down);
    @(negedge clk);
    check($sformatf("enUP@%0d", cyc), enUP, exp_up);
    check($sformatf("enDOWN@%0d", cyc), enDOWN, exp_dn);
    if (enUP) up_idx.push_back(idx);
    if (enDOWN) dn_idx.push_back(idx);
    idx++;
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic window();
    idx = 0;
    up_idx.delete();
    dn_idx.delete();
  endtask

  task automatic check_q(input string tag, input int got[$], input int exp[$]);
    check({tag, " count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s #%0d", tag, i), got[i], exp[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int none[$];
    int e[$];
    int seen;

    reset = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset enUP", enUP, 1'b0);
    check("reset enDOWN", enDOWN, 1'b0);

    // Both held through reset release: LOCK, no pulses.
    btn_up = 1'b1; btn_down = 1'b1;
    #1;
    check("rst both enUP", enUP, 1'b0);
    check("rst both enDOWN", enDOWN, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    window(); steps(14);
    check_q("rst-both up", up_idx, none);
    check_q("rst-both dn", dn_idx, none);
    btn_up = 1'b0; btn_down = 1'b0; steps(12);

    // Up held through reset: one pulse 6 cycles after release.
    reset = 1'b0; model_reset(); btn_up = 1'b1;
    #1;
    check("rst up enUP", enUP, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    window(); steps(14);
    e = {6};
    check_q("rst-up up", up_idx, e);
    btn_up = 1'b0; steps(12);

    // Clean 15-cycle press.
    window(); btn_up = 1'b1; steps(15); btn_up = 1'b0; steps(12);
    e = {6};
    check_q("clean up", up_idx, e);
    check_q("clean dn", dn_idx, none);

    // Bouncing press: toggles every 2 cycles, shorter than the debounce window.
    window();
    for (int c = 0; c < 16; c++) begin
      btn_up = ((c / 2) % 2 == 0);
      step();
    end
    btn_up = 1'b0; steps(12);
    check_q("bounce up", up_idx, none);
    check_q("bounce dn", dn_idx, none);

    // Long hold on down: auto-repeat schedule or a single pulse.
    window(); btn_down = 1'b1; steps(60); btn_down = 1'b0; steps(12);
    if (AR) e = {6, 26, 34, 42, 50, 58};
    else e = {6};
    check_q("hold dn", dn_idx, e);
    check_q("hold up", up_idx, none);

    // Simultaneous press, then down alone while locked; then a fresh down press.
    window(); btn_up = 1'b1; btn_down = 1'b1; steps(30);
    btn_up = 1'b0; steps(30);
    btn_down = 1'b0; steps(12);
    check_q("simul up", up_idx, none);
    check_q("simul dn", dn_idx, none);
    window(); btn_down = 1'b1; steps(12); btn_down = 1'b0; steps(12);
    e = {6};
    check_q("after-lock dn", dn_idx, e);

    // Up held, down joins at cycle 15: one up pulse then LOCK.
    window(); btn_up = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == 15) btn_down = 1'b1;
      step();
    end
    btn_up = 1'b0; btn_down = 1'b0; steps(12);
    e = {6};
    check_q("lockout up", up_idx, e);
    check_q("lockout dn", dn_idx, none);

    // Reset asserted while a pulse is high: output drops at once, held button re-presses.
    window(); btn_up = 1'b1; seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      step();
      if (enUP) seen = 1;
    end
    check("pre-reset pulse seen", seen, 1);
    reset = 1'b0; model_reset();
    #1;
    check("async drop enUP", enUP, 1'b0);
    check("async drop enDOWN", enDOWN, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    window(); steps(14);
    e = {6};
    check_q("re-press up", up_idx, e);
    btn_up = 1'b0; steps(12);

    // Random activity against the model.
    for (int b = 0; b < 60; b++) begin
      btn_up   = ($urandom % 2 == 0);
      btn_down = ($urandom % 4 == 0);
      steps($urandom_range(1, 45));
    end
    btn_up = 1'b0; btn_down = 1'b0; steps(15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/acondicionador_pulsadores_ad.md
# acondicionador_pulsadores_ad

Conditions two raw front-panel push-buttons (up, down) into clean single-cycle `enUP`/`enDOWN` pulses for the day-of-week up/down counter and the other time-field counters of the RTC setting path. Each button passes through a two-flop synchronizer and a per-button debouncer. A shared state machine then issues one pulse per press, with optional auto-repeat while a button is held. Simultaneous presses are rejected.

## Interface
- `DEB_CYCLES`, default 4: consecutive stable cycles required to accept a level change; must be ≥ 1.
- `HOLD_CYCLES`, default 20: cycles from the press pulse to the first repeat pulse; must be ≥ 2.
- `REP_CYCLES`, default 8: period between repeat pulses; must be ≥ 2.
- `CNT_W`, default 24: width of the debounce and repeat timers. Every cycle parameter must be < 2^CNT_W.
- `clk` input, 1: single system clock, rising edge.
- `reset` input, 1: asynchronous, active-low reset.
- `btn_up` input, 1: raw up button, active-high, asynchronous to `clk`.
- `btn_down` input, 1: raw down button, active-high, asynchronous to `clk`.
- `enUP` output, 1: registered one-cycle increment pulse.
- `enDOWN` output, 1: registered one-cycle decrement pulse.

## Operation
- **Reset (`reset`=0):**
  - All registers clear immediately.
  - Synchronizers, debounced levels `up_st`/`dn_st` (released) and timers are 0.
  - FSM goes to IDLE.
  - `enUP`=`enDOWN`=0.
- **Debouncer (per button):**
  - Samples synchronizer output `s2`.
  - If `s2`≠stable, the timer increments. When the timer reaches `DEB_CYCLES`-1 with `s2` still differing, stable takes `s2` and the timer clears.
  - If `s2`==stable, the timer clears.
- **FSM states:** IDLE, ARMED, REPEAT, LOCK. Register `dir` records UP or DOWN. Timer `tmr` is a CNT_W-bit counter.
- **IDLE:**
  - `up_st`&~`dn_st`: pulse `enUP`, set `dir`=UP, clear `tmr`, go to ARMED.
  - `dn_st`&~`up_st`: same with `enDOWN` and `dir`=DOWN.
  - Both pressed: go to LOCK.
  - Neither pressed: stay.
- **ARMED:**
  - Button selected by `dir` released: go to IDLE with no pulse. This has priority.
  - Else the opposite button is pressed: go to LOCK.
  - Else `tmr`==`HOLD_CYCLES`-1: pulse the `dir` output, clear `tmr`, go to REPEAT.
  - Else increment `tmr`.
- **REPEAT:**
  - Same release and opposite-press priority as ARMED.
  - `tmr`==`REP_CYCLES`-1: pulse, then clear `tmr`.
  - Else increment `tmr`.
- **LOCK:** stays until `up_st`=`dn_st`=0, then goes to IDLE. No pulses are issued in LOCK.
- **Output rules:**
  - `enUP` and `enDOWN` are never high in the same cycle.
  - Each pulse is exactly one cycle wide and is followed by at least one low cycle, so the downstream rising-edge detectors see every pulse.

## Timing
- **Press latency:** raw button high before edge k and held. `s1` at k, `s2` at k+1, stable at k+1+`DEB_CYCLES`. The pulse is high in the cycle following edge k+2+`DEB_CYCLES`.
- **Default press latency:** 6 cycles.
- **Release latency:** the same 2+`DEB_CYCLES` path. No pulse is emitted on release.
- **Repeat schedule (with auto-repeat):** pulses at press pulse +`HOLD_CYCLES`, then every `REP_CYCLES`.
- **Glitch filtering:** a glitch shorter than `DEB_CYCLES` cycles at `s2` produces no change.
- **Reset mid-operation:**
  - Outputs drop in the same instant `reset` asserts.
  - After `reset` deasserts with a button still held, that button is treated as a new press: one pulse after 2+`DEB_CYCLES` cycles.

## Configuration
- **`AUTOREPEAT_EN` defined:** ARMED and REPEAT behave as specified above.
- **`AUTOREPEAT_EN` not defined:**
  - ARMED never times out. `tmr` is held at 0 and REPEAT is unreachable.
  - Exactly one pulse is emitted per debounced press, regardless of hold duration.
  - Release and lock behaviour are unchanged.

## Test plan
All scenarios use the defaults: `DEB_CYCLES`=4, `HOLD_CYCLES`=20, `REP_CYCLES`=8.
- Assert `reset`=0 with both buttons high → `enUP`=`enDOWN`=0 immediately. Release `reset` → first pulse 6 cycles later on the held button, or LOCK if both are held.
- `btn_up` clean high for 15 cycles from edge k → `enUP` high only in the cycle after edge k+6; `enDOWN` stays 0 throughout.
- `btn_up` toggling every 2 cycles for 16 cycles, then low → zero pulses on both outputs.
- `btn_down` held for 60 cycles, `AUTOREPEAT_EN` defined → exactly 6 `enDOWN` pulses at k+6, 26, 34, 42, 50, 58. Same stimulus without the macro → exactly 1 pulse at k+6.
- `btn_up` and `btn_down` raised on the same edge for 30 cycles, then `btn_up` dropped with `btn_down` held for 30 more cycles → no pulses. Release both, then press `btn_down` → one `enDOWN` pulse 6 cycles later.
- `btn_up` held 40 cycles, `btn_down` pressed at cycle 15 → a single `enUP` pulse at k+6, then LOCK with no further pulses on either output.
